// File: rtl/gtech_ld_wr_seq_if.sv
// Writer-side bundle for the latch D/G interface: request handshake toward the
// register-file front end plus the registered latch data bus and gate lines.
interface gtech_ld_wr_seq_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
);
  logic             REQ;
  logic [AW-1:0]    ADDR;
  logic [DW-1:0]    WDATA;
  logic             RDY;
  logic [DW-1:0]    LD_D;
  logic [DEPTH-1:0] LD_G;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  // Requester side: issues writes, observes progress.
  modport master (
    output REQ, ADDR, WDATA,
    input  RDY, LD_D, LD_G, BUSY, DONE, ERR
  );

  // Sequencer side: accepts writes, drives the latch bank.
  modport slave (
    input  REQ, ADDR, WDATA,
    output RDY, LD_D, LD_G, BUSY, DONE, ERR
  );
endinterface

// File: rtl/gtech_ld_wr_seq.sv
// Write sequencer for a bank of level-sensitive latches. Every accepted write
// runs SETUP -> GATE -> HOLD so the shared data bus is stable for a full cycle
// on both sides of the gate pulse. All outputs come straight from flops, so the
// gate lines cannot glitch.
module gtech_ld_wr_seq #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int AW        = 2,
  parameter int PULSE_CYC = 1
) (
  input  logic             CP,
  input  logic             CD,
  gtech_ld_wr_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    GATE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYC - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    ldData_q, ldData_d;
  logic [DEPTH-1:0] ldGate_q, ldGate_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             inRange;

  assign inRange = (int'(addr_q) < DEPTH);

  // Next-state and next-output logic; outputs are derived from the next state
  // so that every output pin is a plain flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    ldData_d = ldData_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ldGate_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.REQ) begin
          addr_d   = bus.ADDR;
          ldData_d = bus.WDATA;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = GATE;
        cnt_d   = PULSE_LOAD;
      end
      GATE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        done_d  = 1'b1;
        err_d   = !inRange;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);

    if (state_d == GATE) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (int'(addr_d) == r) begin
          ldGate_d[r] = 1'b1;
        end
      end
    end
  end

  // State and output registers; reset clears the gate lines immediately.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      ldData_q <= '0;
      ldGate_q <= '0;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      ldData_q <= ldData_d;
      ldGate_q <= ldGate_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.RDY  = rdy_q;
  assign bus.LD_D = ldData_q;
  assign bus.LD_G = ldGate_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.ERR  = err_q;

endmodule

// File: tb/tb_gtech_ld_wr_seq.sv
// Directed bench for gtech_ld_wr_seq. Three instances cover the parameter
// corners: 4 rows with a 1-cycle pulse, 4 rows with a 3-cycle pulse, and 3 rows
// (so address 3 is out of range) with a 1-cycle pulse.
module tb_gtech_ld_wr_seq;

  logic CP = 1'b0;
  logic CD = 1'b0;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 CP = ~CP;

  gtech_ld_wr_seq_if #(.DW(8), .DEPTH(4), .AW(2)) if1 ();
  gtech_ld_wr_seq_if #(.DW(8), .DEPTH(4), .AW(2)) if3 ();
  gtech_ld_wr_seq_if #(.DW(8), .DEPTH(3), .AW(2)) ifR ();

  gtech_ld_wr_seq #(.DW(8), .DEPTH(4), .AW(2), .PULSE_CYC(1)) dut1 (
    .CP(CP), .CD(CD), .bus(if1.slave));
  gtech_ld_wr_seq #(.DW(8), .DEPTH(4), .AW(2), .PULSE_CYC(3)) dut3 (
    .CP(CP), .CD(CD), .bus(if3.slave));
  gtech_ld_wr_seq #(.DW(8), .DEPTH(3), .AW(2), .PULSE_CYC(1)) dutR (
    .CP(CP), .CD(CD), .bus(ifR.slave));

  // Advance one cycle and sample just after the rising edge.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  // Reset values while CD is held low, then release.
  task automatic test_reset();
    #12;
    checkCount++;
    if ({if1.RDY, if1.BUSY, if1.DONE, if1.ERR, if1.LD_G} !== 8'b1000_0000) begin
      $display("[TB] FAIL reset_ctl: got %b expected %b",
               {if1.RDY, if1.BUSY, if1.DONE, if1.ERR, if1.LD_G}, 8'b1000_0000);
    end else passCount++;
    checkCount++;
    if (if1.LD_D !== 8'h00) begin
      $display("[TB] FAIL reset_ldd: got %h expected %h", if1.LD_D, 8'h00);
    end else passCount++;
    CD = 1'b1;
    tick();
  endtask

  // ADDR=2, WDATA=A5 with a 1-cycle pulse.
  task automatic test_single();
    logic [7:0] expCtl [5];
    expCtl = '{8'b0100_0000, 8'b0100_0100, 8'b0100_0000, 8'b1010_0000, 8'b1000_0000};
    if1.REQ = 1'b1; if1.ADDR = 2'd2; if1.WDATA = 8'hA5;
    tick();
    if1.REQ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkCount++;
      if ({if1.RDY, if1.BUSY, if1.DONE, if1.ERR, if1.LD_G} !== expCtl[i]) begin
        $display("[TB] FAIL single_ctl[N+%0d]: got %b expected %b", i + 1,
                 {if1.RDY, if1.BUSY, if1.DONE, if1.ERR, if1.LD_G}, expCtl[i]);
      end else passCount++;
      checkCount++;
      if (if1.LD_D !== 8'hA5) begin
        $display("[TB] FAIL single_ldd[N+%0d]: got %h expected %h", i + 1, if1.LD_D, 8'hA5);
      end else passCount++;
      if (i < 4) tick();
    end
  endtask

  // ADDR=0, WDATA=3C with a 3-cycle pulse.
  task automatic test_pulse3();
    logic [7:0] expCtl [7];
    expCtl = '{8'b0100_0000, 8'b0100_0001, 8'b0100_0001, 8'b0100_0001,
               8'b0100_0000, 8'b1010_0000, 8'b1000_0000};
    if3.REQ = 1'b1; if3.ADDR = 2'd0; if3.WDATA = 8'h3C;
    tick();
    if3.REQ = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checkCount++;
      if ({if3.RDY, if3.BUSY, if3.DONE, if3.ERR, if3.LD_G} !== expCtl[i] ||
          if3.LD_D !== 8'h3C) begin
        $display("[TB] FAIL pulse3[N+%0d]: got %b/%h expected %b/%h", i + 1,
                 {if3.RDY, if3.BUSY, if3.DONE, if3.ERR, if3.LD_G}, if3.LD_D,
                 expCtl[i], 8'h3C);
      end else passCount++;
      if (i < 6) tick();
    end
  endtask

  // Second write (3,22) held while the first (1,11) runs; accepted in DONE.
  task automatic test_back_to_back();
    logic [7:0] expCtl [8];
    logic [7:0] expData [8];
    expCtl  = '{8'b0100_0000, 8'b0100_0010, 8'b0100_0000, 8'b1010_0000,
                8'b0100_0000, 8'b0100_1000, 8'b0100_0000, 8'b1010_0000};
    expData = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
    if1.REQ = 1'b1; if1.ADDR = 2'd1; if1.WDATA = 8'h11;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        if1.ADDR = 2'd3; if1.WDATA = 8'h22;
      end
      if (i == 4) if1.REQ = 1'b0;
      checkCount++;
      if ({if1.RDY, if1.BUSY, if1.DONE, if1.ERR, if1.LD_G} !== expCtl[i] ||
          if1.LD_D !== expData[i]) begin
        $display("[TB] FAIL b2b[N+%0d]: got %b/%h expected %b/%h", i + 1,
                 {if1.RDY, if1.BUSY, if1.DONE, if1.ERR, if1.LD_G}, if1.LD_D,
                 expCtl[i], expData[i]);
      end else passCount++;
      if (i < 7) tick();
    end
  endtask

  // Request (1,77) raised while busy with (2,5A) must wait for the DONE cycle.
  task automatic test_stall();
    logic [7:0] expCtl [8];
    logic [7:0] expData [8];
    expCtl  = '{8'b0100_0000, 8'b0100_0100, 8'b0100_0000, 8'b1010_0000,
                8'b0100_0000, 8'b0100_0010, 8'b0100_0000, 8'b1010_0000};
    expData = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h77, 8'h77, 8'h77, 8'h77};
    if1.REQ = 1'b1; if1.ADDR = 2'd2; if1.WDATA = 8'h5A;
    tick();
    if1.REQ = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        if1.REQ = 1'b1; if1.ADDR = 2'd1; if1.WDATA = 8'h77;
      end
      if (i == 4) if1.REQ = 1'b0;
      checkCount++;
      if ({if1.RDY, if1.BUSY, if1.DONE, if1.ERR, if1.LD_G} !== expCtl[i] ||
          if1.LD_D !== expData[i]) begin
        $display("[TB] FAIL stall[N+%0d]: got %b/%h expected %b/%h", i + 1,
                 {if1.RDY, if1.BUSY, if1.DONE, if1.ERR, if1.LD_G}, if1.LD_D,
                 expCtl[i], expData[i]);
      end else passCount++;
      if (i < 7) tick();
    end
  endtask

  // DEPTH=3: ADDR=3 runs gate-less with ERR; ADDR=2 is the top valid row.
  task automatic test_out_of_range();
    logic [6:0] expCtl [5];
    logic [6:0] expTop [4];
    expCtl = '{7'b0100_000, 7'b0100_000, 7'b0100_000, 7'b1011_000, 7'b1000_000};
    expTop = '{7'b0100_000, 7'b0100_100, 7'b0100_000, 7'b1010_000};
    ifR.REQ = 1'b1; ifR.ADDR = 2'd3; ifR.WDATA = 8'hFF;
    tick();
    ifR.REQ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkCount++;
      if ({ifR.RDY, ifR.BUSY, ifR.DONE, ifR.ERR, ifR.LD_G} !== expCtl[i] ||
          ifR.LD_D !== 8'hFF) begin
        $display("[TB] FAIL oor[N+%0d]: got %b/%h expected %b/%h", i + 1,
                 {ifR.RDY, ifR.BUSY, ifR.DONE, ifR.ERR, ifR.LD_G}, ifR.LD_D,
                 expCtl[i], 8'hFF);
      end else passCount++;
      if (i < 4) tick();
    end
    ifR.REQ = 1'b1; ifR.ADDR = 2'd2; ifR.WDATA = 8'h5C;
    tick();
    ifR.REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkCount++;
      if ({ifR.RDY, ifR.BUSY, ifR.DONE, ifR.ERR, ifR.LD_G} !== expTop[i] ||
          ifR.LD_D !== 8'h5C) begin
        $display("[TB] FAIL top_row[N+%0d]: got %b/%h expected %b/%h", i + 1,
                 {ifR.RDY, ifR.BUSY, ifR.DONE, ifR.ERR, ifR.LD_G}, ifR.LD_D,
                 expTop[i], 8'h5C);
      end else passCount++;
      if (i < 3) tick();
    end
  endtask

  // CD asserted mid-GATE must drop the gate at once and suppress DONE.
  task automatic test_reset_mid();
    if1.REQ = 1'b1; if1.ADDR = 2'd2; if1.WDATA = 8'hA5;
    tick();
    if1.REQ = 1'b0;
    tick();
    checkCount++;
    if (if1.LD_G !== 4'b0100) begin
      $display("[TB] FAIL midrst_gate_pre: got %b expected %b", if1.LD_G, 4'b0100);
    end else passCount++;
    #1 CD = 1'b0;
    #1;
    checkCount++;
    if ({if1.BUSY, if1.DONE, if1.LD_G} !== 6'b00_0000) begin
      $display("[TB] FAIL midrst_async: got %b expected %b",
               {if1.BUSY, if1.DONE, if1.LD_G}, 6'b00_0000);
    end else passCount++;
    #1 CD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++;
      if ({if1.RDY, if1.BUSY, if1.DONE, if1.ERR, if1.LD_G} !== 8'b1000_0000 ||
          if1.LD_D !== 8'h00) begin
        $display("[TB] FAIL midrst_after[%0d]: got %b/%h expected %b/%h", i,
                 {if1.RDY, if1.BUSY, if1.DONE, if1.ERR, if1.LD_G}, if1.LD_D,
                 8'b1000_0000, 8'h00);
      end else passCount++;
    end
  endtask

  initial begin
    if1.REQ = 1'b0; if1.ADDR = '0; if1.WDATA = '0;
    if3.REQ = 1'b0; if3.ADDR = '0; if3.WDATA = '0;
    ifR.REQ = 1'b0; ifR.ADDR = '0; ifR.WDATA = '0;
    test_reset();
    test_single();
    test_pulse3();
    test_back_to_back();
    test_stall();
    test_out_of_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
